icw_ocw_sequencer: RTL and testbench

//  Clocked command front-end for the 8259 interrupt_handler.
//  - Decodes CPU writes (cs_n/wr_n/a0/din) into the ICW1..ICW4 init sequence and the OCW1..OCW3 operation words.
//  - Holds every configuration register the handler consumes: mask, vector base, LTIM, AEOI, read select, EOI command/level.
//  - Sits between the bus buffer and interrupt_handler; it sequences and configures the handler and has no interrupt datapath.

---
 rtl/icw_ocw_sequencer.sv | 144 ++++++++++++++
 tb/tb_icw_ocw_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/icw_ocw_sequencer.sv
// 8259 command front-end: decodes CPU writes into the ICW1..ICW4 init sequence
// and the OCW1..OCW3 operation words, and holds the configuration registers
// that the interrupt handler consumes. There is no interrupt datapath here.
module icw_ocw_sequencer #(
    parameter logic [7:0] IMR_INIT = 8'hFF,
    parameter logic [4:0] VEC_INIT = 5'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       a0,
    input  logic [7:0] din,
    output logic [7:0] ocw1,
    output logic [4:0] vec_add,
    output logic       ltim,
    output logic       sngl,
    output logic [7:0] cascade,
    output logic       eoi_mode,
    output logic       read_mode,
    output logic [2:0] eoi_command,
    output logic [2:0] int_level,
    output logic       eoi_cmd_updated,
    output logic       init_done,
    output logic       seq_err
);

    localparam logic [2:0] ST_UNINIT = 3'd0;
    localparam logic [2:0] ST_W_ICW2 = 3'd1;
    localparam logic [2:0] ST_W_ICW3 = 3'd2;
    localparam logic [2:0] ST_W_ICW4 = 3'd3;
    localparam logic [2:0] ST_READY  = 3'd4;

    logic [2:0] r_state;
    logic       r_arm;
    logic       r_ic4;

    logic       w_accept;
    logic       w_icw1;
    logic       w_ignore;
    logic [2:0] w_state_next;

    // One accept per write pulse: arm is consumed by the accept and only
    // re-armed once the strobe or chip select goes inactive.
    assign w_accept = ~cs_n & ~wr_n & r_arm;
    // ICW1 restarts initialisation from any state.
    assign w_icw1   = ~a0 & din[4];

    // Next-state and out-of-sequence decode for the current accept.
    always_comb begin
        w_state_next = r_state;
        w_ignore     = 1'b0;
        if (w_accept) begin
            if (w_icw1) begin
                w_state_next = ST_W_ICW2;
            end else begin
                case (r_state)
                    ST_W_ICW2: begin
                        if (a0) begin
                            if (!sngl)      w_state_next = ST_W_ICW3;
                            else if (r_ic4) w_state_next = ST_W_ICW4;
                            else            w_state_next = ST_READY;
                        end else begin
                            w_ignore = 1'b1;
                        end
                    end
                    ST_W_ICW3: begin
                        if (a0) w_state_next = r_ic4 ? ST_W_ICW4 : ST_READY;
                        else    w_ignore = 1'b1;
                    end
                    ST_W_ICW4: begin
                        if (a0) w_state_next = ST_READY;
                        else    w_ignore = 1'b1;
                    end
                    ST_READY:  w_state_next = ST_READY;
                    default:   w_ignore = 1'b1;
                endcase
            end
        end
    end

    // Sequencer state, write arming and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_UNINIT;
            r_arm     <= 1'b1;
            init_done <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            init_done <= (w_state_next == ST_READY);
            seq_err   <= w_ignore;
            if (cs_n || wr_n)  r_arm <= 1'b1;
            else if (w_accept) r_arm <= 1'b0;
        end
    end

    // Configuration registers written by accepted ICW/OCW bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ocw1            <= IMR_INIT;
            vec_add         <= VEC_INIT;
            ltim            <= 1'b0;
            sngl            <= 1'b0;
            r_ic4           <= 1'b0;
            cascade         <= 8'h00;
            eoi_mode        <= 1'b0;
            read_mode       <= 1'b0;
            eoi_command     <= 3'b000;
            int_level       <= 3'b000;
            eoi_cmd_updated <= 1'b0;
        end else if (w_accept) begin
            if (w_icw1) begin
                ltim      <= din[3];
                sngl      <= din[1];
                r_ic4     <= din[0];
                ocw1      <= 8'h00;
                eoi_mode  <= 1'b0;
                read_mode <= 1'b0;
            end else begin
                case (r_state)
                    ST_W_ICW2: if (a0) vec_add  <= din[7:3];
                    ST_W_ICW3: if (a0) cascade  <= din;
                    ST_W_ICW4: if (a0) eoi_mode <= din[1];
                    ST_READY: begin
                        if (a0) begin
                            ocw1 <= din;
                        end else if (!din[3]) begin
                            // OCW2: every code is forwarded, the handler interprets it.
                            eoi_command     <= din[7:5];
                            int_level       <= din[2:0];
                            eoi_cmd_updated <= ~eoi_cmd_updated;
                        end else if (din[1]) begin
                            // OCW3: read select only changes when RR is set.
                            read_mode <= din[0];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_icw_ocw_sequencer.sv
// Directed bench for icw_ocw_sequencer: linear sequence of CPU writes with
// hand-computed expected register values, checked with immediate assertions.
module tb_icw_ocw_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs_n = 1'b1;
    logic       wr_n = 1'b1;
    logic       a0 = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] ocw1;
    logic [4:0] vec_add;
    logic       ltim;
    logic       sngl;
    logic [7:0] cascade;
    logic       eoi_mode;
    logic       read_mode;
    logic [2:0] eoi_command;
    logic [2:0] int_level;
    logic       eoi_cmd_updated;
    logic       init_done;
    logic       seq_err;

    int n_vec = 0;
    int n_err = 0;
    logic err_seen;

    always #5 clk = ~clk;

    icw_ocw_sequencer #(.IMR_INIT(8'hFF), .VEC_INIT(5'h00)) dut (
        .clk(clk), .rst(rst), .cs_n(cs_n), .wr_n(wr_n), .a0(a0), .din(din),
        .ocw1(ocw1), .vec_add(vec_add), .ltim(ltim), .sngl(sngl),
        .cascade(cascade), .eoi_mode(eoi_mode), .read_mode(read_mode),
        .eoi_command(eoi_command), .int_level(int_level),
        .eoi_cmd_updated(eoi_cmd_updated), .init_done(init_done),
        .seq_err(seq_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("vec %0d %s obs=%0h exp=%0h", n_vec, tag, obs, exp);
    endtask

    // One write pulse of one clock; err_seen captures seq_err in the cycle after accept.
    task automatic wr(input logic a, input logic [7:0] d);
        @(negedge clk);
        a0 = a; din = d; cs_n = 1'b0; wr_n = 1'b0;
        @(negedge clk);
        err_seen = seq_err;
        cs_n = 1'b1; wr_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ocw1", ocw1, 8'hFF);
        chk("rst_vec", vec_add, 5'h00);
        chk("rst_init_done", init_done, 0);
        chk("rst_seq_err", seq_err, 0);
        chk("rst_upd", eoi_cmd_updated, 0);

        // Out-of-sequence write from UNINIT.
        wr(1'b1, 8'h0F);
        chk("uninit_seq_err_pulse", err_seen, 1);
        chk("uninit_seq_err_clear", seq_err, 0);
        chk("uninit_ocw1", ocw1, 8'hFF);

        // Single, ICW4 sequence.
        wr(1'b0, 8'h13);
        chk("t1_icw1_ocw1", ocw1, 8'h00);
        chk("t1_icw1_init_done", init_done, 0);
        wr(1'b1, 8'h48);
        chk("t1_vec", vec_add, 5'h09);
        chk("t1_icw2_init_done", init_done, 0);
        wr(1'b1, 8'h02);
        chk("t1_eoi_mode", eoi_mode, 1);
        chk("t1_ltim", ltim, 0);
        chk("t1_init_done", init_done, 1);

        // Operation words in READY.
        wr(1'b1, 8'hF0);
        chk("t3_ocw1", ocw1, 8'hF0);
        wr(1'b0, 8'h63);
        chk("t3_eoi_cmd", eoi_command, 3'b011);
        chk("t3_level", int_level, 3'd3);
        chk("t3_upd", eoi_cmd_updated, 1);
        wr(1'b0, 8'h0B);
        chk("t3_read_mode", read_mode, 1);
        chk("t3_upd_hold", eoi_cmd_updated, 1);
        chk("t3_no_seq_err", err_seen, 0);

        // Long write pulse: one accept only, later data ignored.
        @(negedge clk);
        a0 = 1'b1; din = 8'h55; cs_n = 1'b0; wr_n = 1'b0;
        repeat (3) @(negedge clk);
        din = 8'hAA;
        repeat (7) @(negedge clk);
        chk("t4_hold_ocw1", ocw1, 8'h55);
        cs_n = 1'b1; wr_n = 1'b1;
        @(negedge clk);
        wr(1'b0, 8'h20);
        chk("t4_upd_first", eoi_cmd_updated, 0);
        wr(1'b0, 8'hA5);
        chk("t4_upd_second", eoi_cmd_updated, 1);
        chk("t4_eoi_cmd", eoi_command, 3'b101);
        chk("t4_level", int_level, 3'd5);

        // ICW1 while READY restarts initialisation.
        wr(1'b0, 8'h18);
        chk("t6_icw1_ocw1", ocw1, 8'h00);
        chk("t6_icw1_init_done", init_done, 0);
        chk("t6_icw1_eoi_mode", eoi_mode, 0);
        chk("t6_icw1_read_mode", read_mode, 0);
        chk("t6_icw1_ltim", ltim, 1);
        chk("t6_icw1_eoi_cmd", eoi_command, 3'b101);
        chk("t6_icw1_upd", eoi_cmd_updated, 1);

        // OCW2 during W_ICW2 is ignored.
        wr(1'b0, 8'h00);
        chk("t5_wicw2_seq_err", err_seen, 1);
        chk("t5_wicw2_eoi_cmd", eoi_command, 3'b101);
        chk("t5_wicw2_upd", eoi_cmd_updated, 1);

        // Cascade, no ICW4: READY straight after ICW3.
        wr(1'b1, 8'h20);
        chk("t2_vec", vec_add, 5'h04);
        chk("t2_icw2_init_done", init_done, 0);
        wr(1'b1, 8'h04);
        chk("t2_cascade", cascade, 8'h04);
        chk("t2_init_done", init_done, 1);
        chk("t2_eoi_mode", eoi_mode, 0);

        // OCW3 without RR leaves read select alone.
        wr(1'b0, 8'h09);
        chk("ocw3_norr_read_mode", read_mode, 0);

        // Async reset while waiting for ICW3, with a write held across release.
        wr(1'b0, 8'h18);
        wr(1'b1, 8'h20);
        chk("t6_pre_rst_init_done", init_done, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_ocw1", ocw1, 8'hFF);
        chk("t6_rst_init_done", init_done, 0);
        chk("t6_rst_vec", vec_add, 5'h00);
        chk("t6_rst_cascade", cascade, 8'h00);
        a0 = 1'b0; din = 8'h13; cs_n = 1'b0; wr_n = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_accept_ocw1", ocw1, 8'h00);
        cs_n = 1'b1; wr_n = 1'b1;
        @(negedge clk);
        wr(1'b1, 8'h48);
        chk("icw4_path_init_done", init_done, 0);
        wr(1'b1, 8'h00);
        chk("icw4_path_done", init_done, 1);
        chk("icw4_path_eoi_mode", eoi_mode, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
